alu_lockstep_monitor: RTL and testbench

//   Consumes the registered outputs of alu_clean and alu_trojan running in lockstep.

---
 rtl/alu_lockstep_monitor.sv | 130 +++++++++++++
 tb/tb_alu_lockstep_monitor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_lockstep_monitor.sv
// alu_lockstep_monitor: compares lockstep clean/trojan ALU outputs, counts samples and
// mismatches, captures the first divergence and raises a sticky alarm on clustered mismatches.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   i_valid, i_a, i_b, i_op             sample qualifier and the operands/opcode that produced it
//   i_res/cout/zero_clean, _trojan      outputs of the two ALUs under comparison
//   i_clr                               synchronous clear of counters, capture, alarm and FSM
//   o_mismatch                          one-cycle pulse: previous valid sample diverged
//   o_alarm, o_state                    sticky alarm; FSM state (00 MONITOR, 01 SUSPECT, 10 ALARM)
//   o_sample_cnt, o_mism_cnt            saturating sample / mismatch counters
//   o_cap_*                             first-mismatch capture (valid flag, operands, opcode, results)
module alu_lockstep_monitor #(
    parameter int DATA_W       = 4,
    parameter int CNT_W        = 16,
    parameter int ALARM_THRESH = 3,
    parameter int WINDOW       = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_res_clean,
    input  logic              i_cout_clean,
    input  logic              i_zero_clean,
    input  logic [DATA_W-1:0] i_res_trojan,
    input  logic              i_cout_trojan,
    input  logic              i_zero_trojan,
    input  logic              i_clr,
    output logic              o_mismatch,
    output logic              o_alarm,
    output logic [1:0]        o_state,
    output logic [CNT_W-1:0]  o_sample_cnt,
    output logic [CNT_W-1:0]  o_mism_cnt,
    output logic              o_cap_valid,
    output logic [DATA_W-1:0] o_cap_a,
    output logic [DATA_W-1:0] o_cap_b,
    output logic [1:0]        o_cap_op,
    output logic [DATA_W-1:0] o_cap_res_c,
    output logic [DATA_W-1:0] o_cap_res_t
);
    typedef enum logic [1:0] {MONITOR = 2'b00, SUSPECT = 2'b01, ALARM = 2'b10} state_t;
    state_t            r_state, w_state_nxt;
    logic [15:0]       r_timer, w_timer_nxt;
    logic [7:0]        r_win_cnt, w_win_cnt_nxt;
    logic [8:0]        w_win_sum;
    logic              w_diff;
    logic              r_mismatch, r_cap_valid;
    logic [CNT_W-1:0]  r_sample_cnt, r_mism_cnt;
    logic [DATA_W-1:0] r_cap_a, r_cap_b, r_cap_res_c, r_cap_res_t;
    logic [1:0]        r_cap_op;

    assign w_diff    = i_valid & ({i_res_clean, i_cout_clean, i_zero_clean} !=
                                  {i_res_trojan, i_cout_trojan, i_zero_trojan});
    // Window count including the current sample; the threshold test sees this sum.
    assign w_win_sum = {1'b0, r_win_cnt} + 9'(w_diff);

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_win_cnt_nxt = r_win_cnt;
        case (r_state)
            MONITOR: if (w_diff) begin
                w_state_nxt   = (ALARM_THRESH == 1) ? ALARM : SUSPECT;
                w_timer_nxt   = 16'd1;
                w_win_cnt_nxt = 8'd1;
            end
            SUSPECT: if (w_win_sum >= 9'(ALARM_THRESH)) begin
                w_state_nxt   = ALARM;
            end else if (r_timer == 16'(WINDOW)) begin
                // Window expired: a diff on the closing cycle opens a fresh window.
                w_state_nxt   = w_diff ? SUSPECT : MONITOR;
                w_timer_nxt   = w_diff ? 16'd1 : 16'd0;
                w_win_cnt_nxt = w_diff ? 8'd1 : 8'd0;
            end else begin
                w_timer_nxt   = r_timer + 16'd1;
                w_win_cnt_nxt = w_win_sum[7:0];
            end
            ALARM:   w_state_nxt = ALARM;
            default: w_state_nxt = MONITOR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || i_clr) begin
            r_state      <= MONITOR;
            r_timer      <= '0;
            r_win_cnt    <= '0;
            r_mismatch   <= 1'b0;
            r_sample_cnt <= '0;
            r_mism_cnt   <= '0;
            r_cap_valid  <= 1'b0;
            r_cap_a      <= '0;
            r_cap_b      <= '0;
            r_cap_op     <= '0;
            r_cap_res_c  <= '0;
            r_cap_res_t  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_win_cnt  <= w_win_cnt_nxt;
            r_mismatch <= w_diff;
            if (i_valid && !(&r_sample_cnt))
                r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            if (w_diff && !(&r_mism_cnt))
                r_mism_cnt <= r_mism_cnt + CNT_W'(1);
            if (w_diff && !r_cap_valid) begin
                r_cap_valid <= 1'b1;
                r_cap_a     <= i_a;
                r_cap_b     <= i_b;
                r_cap_op    <= i_op;
                r_cap_res_c <= i_res_clean;
                r_cap_res_t <= i_res_trojan;
            end
        end
    end

    assign o_mismatch   = r_mismatch;
    assign o_alarm      = (r_state == ALARM);
    assign o_state      = r_state;
    assign o_sample_cnt = r_sample_cnt;
    assign o_mism_cnt   = r_mism_cnt;
    assign o_cap_valid  = r_cap_valid;
    assign o_cap_a      = r_cap_a;
    assign o_cap_b      = r_cap_b;
    assign o_cap_op     = r_cap_op;
    assign o_cap_res_c  = r_cap_res_c;
    assign o_cap_res_t  = r_cap_res_t;
endmodule

// File: tb/tb_alu_lockstep_monitor.sv
// tb_alu_lockstep_monitor: directed scoreboard bench for alu_lockstep_monitor (default and CNT_W=4 instances).
module tb_alu_lockstep_monitor;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       valid = 1'b0, clr = 1'b0;
    logic [3:0] a_in = '0, b_in = '0, res_c = '0, res_t = '0;
    logic [1:0] op_in = '0;
    logic       cout_c = 1'b0, zero_c = 1'b0, cout_t = 1'b0, zero_t = 1'b0;
    logic       mismatch, alarm, cap_valid;
    logic [1:0] state, cap_op;
    logic [15:0] sample_cnt, mism_cnt;
    logic [3:0] cap_a, cap_b, cap_res_c, cap_res_t;
    logic       mismatch4, alarm4, cap_valid4;
    logic [1:0] state4, cap_op4;
    logic [3:0] sample_cnt4, mism_cnt4, cap_a4, cap_b4, cap_res_c4, cap_res_t4;
    int errors = 0, checks = 0;
    int m_s = 0, m_c = 0;

    typedef struct {
        logic        m;
        logic [15:0] s;
        logic [15:0] c;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_lockstep_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .i_valid(valid), .i_a(a_in), .i_b(b_in), .i_op(op_in),
        .i_res_clean(res_c), .i_cout_clean(cout_c), .i_zero_clean(zero_c),
        .i_res_trojan(res_t), .i_cout_trojan(cout_t), .i_zero_trojan(zero_t), .i_clr(clr),
        .o_mismatch(mismatch), .o_alarm(alarm), .o_state(state), .o_sample_cnt(sample_cnt),
        .o_mism_cnt(mism_cnt), .o_cap_valid(cap_valid), .o_cap_a(cap_a), .o_cap_b(cap_b),
        .o_cap_op(cap_op), .o_cap_res_c(cap_res_c), .o_cap_res_t(cap_res_t));

    alu_lockstep_monitor #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_valid(valid), .i_a(a_in), .i_b(b_in), .i_op(op_in),
        .i_res_clean(res_c), .i_cout_clean(cout_c), .i_zero_clean(zero_c),
        .i_res_trojan(res_t), .i_cout_trojan(cout_t), .i_zero_trojan(zero_t), .i_clr(clr),
        .o_mismatch(mismatch4), .o_alarm(alarm4), .o_state(state4), .o_sample_cnt(sample_cnt4),
        .o_mism_cnt(mism_cnt4), .o_cap_valid(cap_valid4), .o_cap_a(cap_a4), .o_cap_b(cap_b4),
        .o_cap_op(cap_op4), .o_cap_res_c(cap_res_c4), .o_cap_res_t(cap_res_t4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus; flip corrupts the trojan result LSB.
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input logic flip, input logic c);
        logic [4:0] s;
        logic d;
        exp_t e;
        case (op)
            2'd0:    s = {1'b0, a} + {1'b0, b};
            2'd1:    s = {1'b0, a} - {1'b0, b};
            2'd2:    s = {1'b0, a & b};
            default: s = {1'b0, a | b};
        endcase
        valid = v; a_in = a; b_in = b; op_in = op; clr = c;
        res_c = s[3:0]; cout_c = s[4]; zero_c = (s[3:0] == 4'd0);
        res_t = s[3:0] ^ {3'b0, flip}; cout_t = cout_c; zero_t = zero_c;
        d = v & flip & ~c;
        if (c) begin
            m_s = 0;
            m_c = 0;
        end else begin
            if (v && m_s < 65535) m_s++;
            if (d && m_c < 65535) m_c++;
        end
        q.push_back('{d, 16'(m_s), 16'(m_c)});
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("mismatch_o", 32'(mismatch), 32'(e.m));
            chk("sample_cnt", 32'(sample_cnt), 32'(e.s));
            chk("mism_cnt", 32'(mism_cnt), 32'(e.c));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_alarm", 32'(alarm), 32'h0);
        chk("rst_sample", 32'(sample_cnt), 32'h0);
        chk("rst_mism", 32'(mism_cnt), 32'h0);
        chk("rst_cap_valid", 32'(cap_valid), 32'h0);
        chk("rst_mismatch", 32'(mismatch), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 1024; i++) begin
            step(1'b1, i[3:0], i[7:4], i[9:8], 1'b0, 1'b0);
            if (i == 13) chk("cnt4_14", 32'(sample_cnt4), 32'd14);
            if (i == 19) chk("cnt4_sat", 32'(sample_cnt4), 32'd15);
        end
        chk("exh_sample", 32'(sample_cnt), 32'd1024);
        chk("exh_mism", 32'(mism_cnt), 32'd0);
        chk("exh_state", 32'(state), 32'h0);
        chk("cnt4_sat_end", 32'(sample_cnt4), 32'd15);

        step(1'b1, 4'hF, 4'hF, 2'd0, 1'b1, 1'b0);
        chk("d1_state", 32'(state), 32'h1);
        chk("d1_cap_valid", 32'(cap_valid), 32'h1);
        chk("d1_cap_a", 32'(cap_a), 32'hF);
        chk("d1_cap_b", 32'(cap_b), 32'hF);
        chk("d1_cap_op", 32'(cap_op), 32'h0);
        chk("d1_cap_res_c", 32'(cap_res_c), 32'hE);
        chk("d1_cap_res_t", 32'(cap_res_t), 32'hF);
        step(1'b1, 4'h2, 4'h3, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'h1, 4'h2, 2'd0, 1'b1, 1'b0);
        chk("d2_state", 32'(state), 32'h1);
        chk("d2_alarm", 32'(alarm), 32'h0);
        step(1'b1, 4'h7, 4'h2, 2'd1, 1'b1, 1'b0);
        chk("d3_state", 32'(state), 32'h2);
        chk("d3_alarm", 32'(alarm), 32'h1);
        chk("d3_cap_frozen", 32'(cap_a), 32'hF);
        for (int i = 0; i < 100; i++) step(1'b1, i[3:0], i[7:4], 2'd3, 1'b0, 1'b0);
        chk("alarm_sticky", 32'(alarm), 32'h1);
        chk("alarm_state", 32'(state), 32'h2);

        step(1'b1, 4'h9, 4'h9, 2'd0, 1'b1, 1'b1);
        clr = 1'b0;
        chk("clr_state", 32'(state), 32'h0);
        chk("clr_alarm", 32'(alarm), 32'h0);
        chk("clr_cap_valid", 32'(cap_valid), 32'h0);
        chk("clr_cap_a", 32'(cap_a), 32'h0);
        chk("clr_cnt4", 32'(sample_cnt4), 32'h0);

        step(1'b1, 4'h3, 4'h4, 2'd1, 1'b1, 1'b0);
        step(1'b1, 4'h5, 4'h6, 2'd2, 1'b1, 1'b0);
        chk("w2_state", 32'(state), 32'h1);
        for (int i = 0; i < 62; i++) step(1'b1, i[3:0], 4'h1, 2'd0, 1'b0, 1'b0);
        chk("w_before_expiry", 32'(state), 32'h1);
        step(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
        chk("w_expired", 32'(state), 32'h0);
        chk("w_cap_a", 32'(cap_a), 32'h3);
        chk("w_cap_b", 32'(cap_b), 32'h4);
        chk("w_cap_op", 32'(cap_op), 32'h1);
        chk("w_mism", 32'(mism_cnt), 32'd2);

        step(1'b1, 4'hA, 4'h5, 2'd3, 1'b1, 1'b0);
        step(1'b1, 4'h1, 4'h1, 2'd0, 1'b0, 1'b0);
        chk("pre_rst_state", 32'(state), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'h0);
        chk("arst_sample", 32'(sample_cnt), 32'h0);
        chk("arst_mism", 32'(mism_cnt), 32'h0);
        chk("arst_cap_valid", 32'(cap_valid), 32'h0);
        chk("arst_alarm", 32'(alarm), 32'h0);
        chk("arst_cnt4", 32'(sample_cnt4), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
